keyboard_fifo_ctrl: RTL and testbench
=====================================

// Module: keyboard_fifo_ctrl
// PURPOSE
//  Buffers and sequences set-1 key codes from the PS/2 decode chain for the CPU.
//  Pushes one 16-bit code per key_valid pulse into a FIFO. Exposes DATA/STATUS/CTRL
//  registers on the peripheral read/write bus. Drives a maskable level interrupt
//  while codes are pending. Replaces the direct single-register keyboard read path.
// PARAMETERS
//  DEPTH      8        FIFO entries; power of 2, >= 2
//  PTR_W      3        log2(DEPTH)
//  BASE_ADDR  16'h0000 address of DATA; STATUS = BASE+1, CTRL = BASE+2
// PORTS
//  global_clk    in   1   system clock; all logic on rising edge
//  global_rst_n  in   1   asynchronous active-low reset
//  key_valid     in   1   one-cycle strobe: key_code holds a new set-1 code
//  key_code      in   16  translated code; bit 7 = break
//  bus_addr      in   16  peripheral address
//  bus_rd        in   1   read strobe, one cycle per access
//  bus_wr        in   1   write strobe, one cycle per access
//  bus_wdata     in   16  write data
//  bus_rdata     out  16  registered read data
//  key_irq       out  1   interrupt request, level
// BEHAVIOUR
//  Reset: FIFO empty, pointers 0, count 0, overflow 0, irq_en 0,
//   bus_rdata 16'h0000, key_irq 0.
//  Read latency: bus_rdata is valid 1 cycle after the bus_rd/bus_addr edge.
//   With no bus_rd, or an unmapped address, bus_rdata is 16'h0000 next cycle.
//  DATA (BASE+0) read:
//   - Not empty: returns head entry and pops it (rd_ptr+1, count-1).
//   - Empty: returns 16'h0000; no pop.
//   - DATA write: ignored.
//  STATUS (BASE+1), read-only, no side effects:
//   [15] overflow (sticky), [14] empty, [13] full, [PTR_W:0] count, other bits 0.
//  CTRL (BASE+2) write:
//   - bit0: irq_en, stored.
//   - bit1=1: flush. Pointers and count go to 0; self-clearing.
//   - bit2=1: clear overflow.
//  CTRL read: {15'b0, irq_en}.
//  Push: on key_valid, key_code is written at wr_ptr; wr_ptr+1, count+1.
//  Pointers wrap modulo DEPTH. Count range is 0..DEPTH (PTR_W+1 bits).
//  Simultaneous events, all in the same cycle:
//   - Push while full, no pop: code dropped; overflow <= 1; FIFO unchanged.
//   - Push and pop while full: both occur; count stays DEPTH; no overflow.
//   - Push and pop while empty: read returns 0; push is stored; count becomes 1.
//   - Flush and push: flush wins; the pushed code is discarded; count 0.
//   - Flush and DATA read: read returns the pre-flush head; FIFO ends empty.
//   - Clear-overflow and overflowing push: overflow stays 1 (set wins).
//  key_irq: registered, = irq_en & (count != 0) as of the previous cycle.
//   It deasserts the cycle after the pop that empties the FIFO.
//  Reset mid-operation: all state returns to reset values immediately
//   (asynchronous). A key_valid during reset is lost.
// TESTING
//  1. Push 16'h001E, then 16'h009E; read DATA twice
//     -> 001E, then 009E; STATUS then reads 16'h4000.
//  2. irq_en=1; push 1 code -> key_irq rises 1 cycle after push;
//     DATA read -> key_irq falls the cycle after the read.
//  3. Push 9 codes 16'h0001..0009 (DEPTH=8) -> STATUS = 16'hA008;
//     reads return 0001..0008; 0009 is lost.
//  4. Full FIFO, key_valid and DATA read in the same cycle
//     -> returns oldest code; count stays 8; overflow stays 0.
//  5. 3 codes queued; write CTRL=16'h0006 together with key_valid
//     -> STATUS = 16'h4000; next DATA read = 16'h0000.
//  6. Assert global_rst_n=0 mid-stream with 5 queued and irq_en=1
//     -> key_irq 0, bus_rdata 0, STATUS 16'h4000 after release.

Source files
------------

// File: rtl/keyboard_fifo_ctrl.sv
// Keyboard code FIFO with a DATA/STATUS/CTRL register window and a maskable level IRQ.
// Sits between the PS/2 set-1 decode chain and the CPU peripheral bus.
module keyboard_fifo_ctrl #(
  parameter int          DEPTH     = 8,
  parameter int          PTR_W     = 3,
  parameter logic [15:0] BASE_ADDR = 16'h0000
) (
  input  logic        global_clk,
  input  logic        global_rst_n,
  input  logic        key_valid,
  input  logic [15:0] key_code,
  input  logic [15:0] bus_addr,
  input  logic        bus_rd,
  input  logic        bus_wr,
  input  logic [15:0] bus_wdata,
  output logic [15:0] bus_rdata,
  output logic        key_irq
);

  localparam logic [15:0]      ADDR_DATA   = BASE_ADDR;
  localparam logic [15:0]      ADDR_STATUS = BASE_ADDR + 16'd1;
  localparam logic [15:0]      ADDR_CTRL   = BASE_ADDR + 16'd2;
  localparam logic [PTR_W:0]   FULL_CNT    = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE     = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE     = PTR_W'(1);

  logic [15:0]      mem_q [DEPTH];
  logic [15:0]      mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             irq_en_q, irq_en_d;
  logic [15:0]      rdata_q, rdata_d;
  logic             irq_q, irq_d;

  logic             empty_s, full_s;
  logic             data_rd_s, pop_s, push_s, ovf_set_s;
  logic             ctrl_wr_s, flush_s, clr_ovf_s;
  logic [15:0]      status_s;
  logic             unused_wdata_s;

  assign unused_wdata_s = ^bus_wdata[15:3];

  // Event decode: a pop needs data present; a push needs room unless a pop frees a slot.
  always_comb begin
    empty_s   = (count_q == '0);
    full_s    = (count_q == FULL_CNT);
    data_rd_s = bus_rd & (bus_addr == ADDR_DATA);
    pop_s     = data_rd_s & ~empty_s;
    ctrl_wr_s = bus_wr & (bus_addr == ADDR_CTRL);
    flush_s   = ctrl_wr_s & bus_wdata[1];
    clr_ovf_s = ctrl_wr_s & bus_wdata[2];
    push_s    = key_valid & ~flush_s & (~full_s | pop_s);
    ovf_set_s = key_valid & ~flush_s & full_s & ~pop_s;
    status_s  = 16'h0000;
    status_s[15]      = overflow_q;
    status_s[14]      = empty_s;
    status_s[13]      = full_s;
    status_s[PTR_W:0] = count_q;
  end

  // Next-state for storage, pointers, count and control bits; flush overrides both push and pop.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    irq_en_d   = irq_en_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = key_code;
    end else begin
      mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
    end
    if (flush_s) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
    if (ovf_set_s) begin
      overflow_d = 1'b1;
    end else if (clr_ovf_s) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
    if (ctrl_wr_s) begin
      irq_en_d = bus_wdata[0];
    end else begin
      irq_en_d = irq_en_q;
    end
  end

  // Read mux sees pre-update state, so a read in a flush cycle still returns the old head.
  always_comb begin
    rdata_d = 16'h0000;
    irq_d   = irq_en_q & ~empty_s;
    if (bus_rd) begin
      case (bus_addr)
        ADDR_DATA:   rdata_d = pop_s ? mem_q[rd_ptr_q] : 16'h0000;
        ADDR_STATUS: rdata_d = status_s;
        ADDR_CTRL:   rdata_d = {15'b0, irq_en_q};
        default:     rdata_d = 16'h0000;
      endcase
    end else begin
      rdata_d = 16'h0000;
    end
  end

  // State registers.
  always_ff @(posedge global_clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      mem_q      <= '{default: 16'h0000};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      irq_en_q   <= 1'b0;
      rdata_q    <= 16'h0000;
      irq_q      <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      irq_en_q   <= irq_en_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
    end
  end

  assign bus_rdata = rdata_q;
  assign key_irq   = irq_q;

endmodule

// File: tb/tb_keyboard_fifo_ctrl.sv
// Directed bench for keyboard_fifo_ctrl: a vector table run one cycle per entry,
// plus hand-written reset sequences.
module tb_keyboard_fifo_ctrl;

  logic        global_clk;
  logic        global_rst_n;
  logic        key_valid;
  logic [15:0] key_code;
  logic [15:0] bus_addr;
  logic        bus_rd;
  logic        bus_wr;
  logic [15:0] bus_wdata;
  logic [15:0] bus_rdata;
  logic        key_irq;

  int checks;
  int failures;

  typedef struct {
    logic        kv;
    logic [15:0] code;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic        exp_irq;
  } vec_t;

  vec_t vq[$];

  keyboard_fifo_ctrl #(.DEPTH(8), .PTR_W(3), .BASE_ADDR(16'h0000)) dut (
    .global_clk  (global_clk),
    .global_rst_n(global_rst_n),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .bus_addr    (bus_addr),
    .bus_rd      (bus_rd),
    .bus_wr      (bus_wr),
    .bus_wdata   (bus_wdata),
    .bus_rdata   (bus_rdata),
    .key_irq     (key_irq)
  );

  initial global_clk = 1'b0;
  always #5 global_clk = ~global_clk;

  function automatic vec_t mk(input logic kv, input logic [15:0] code, input logic rd,
                              input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                              input logic [15:0] exp_rdata, input logic exp_irq);
    vec_t v;
    v.kv = kv; v.code = code; v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_irq = exp_irq;
    return v;
  endfunction

  function automatic void push(input logic [15:0] c, input logic irq);
    vq.push_back(mk(1'b1, c, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, irq));
  endfunction
  function automatic void rd_data(input logic [15:0] e, input logic irq);
    vq.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, e, irq));
  endfunction
  function automatic void rd_stat(input logic [15:0] e);
    vq.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0001, 16'h0000, e, 1'b0));
  endfunction
  function automatic void wr_ctrl(input logic [15:0] w);
    vq.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0002, w, 16'h0000, 1'b0));
  endfunction

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic drive(input logic kv, input logic [15:0] code, input logic rd, input logic wr,
                       input logic [15:0] addr, input logic [15:0] wdata);
    key_valid = kv; key_code = code; bus_rd = rd; bus_wr = wr; bus_addr = addr; bus_wdata = wdata;
  endtask

  task automatic step(input logic kv, input logic [15:0] code, input logic rd, input logic wr,
                      input logic [15:0] addr, input logic [15:0] wdata);
    drive(kv, code, rd, wr, addr, wdata);
    @(posedge global_clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    global_rst_n = 1'b0;
    repeat (2) @(posedge global_clk);
    #1;
    chk16("reset_rdata", bus_rdata, 16'h0000);
    chk1("reset_irq", key_irq, 1'b0);
    @(negedge global_clk);
    global_rst_n = 1'b1;
    @(posedge global_clk);
    #1;

    // Two codes in, two codes out in order, then empty.
    push(16'h001E, 1'b0); push(16'h009E, 1'b0);
    rd_data(16'h001E, 1'b0); rd_data(16'h009E, 1'b0); rd_stat(16'h4000);
    // IRQ rises one cycle after the push, falls one cycle after the emptying read.
    wr_ctrl(16'h0001); push(16'h0055, 1'b0);
    vq.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1));
    rd_data(16'h0055, 1'b1);
    vq.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0));
    vq.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0002, 16'h0000, 16'h0001, 1'b0));
    wr_ctrl(16'h0000);
    // Overflow: the ninth code is dropped.
    for (int i = 1; i <= 9; i++) push(16'(i), 1'b0);
    rd_stat(16'hA008);
    for (int i = 1; i <= 8; i++) rd_data(16'(i), 1'b0);
    rd_stat(16'hC000); wr_ctrl(16'h0004); rd_stat(16'h4000);
    // Full FIFO: push together with a pop keeps count at DEPTH, no overflow.
    for (int i = 1; i <= 8; i++) push(16'h0100 + 16'(i), 1'b0);
    vq.push_back(mk(1'b1, 16'h0109, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0101, 1'b0));
    rd_stat(16'h2008); rd_data(16'h0102, 1'b0); rd_stat(16'h0007);
    wr_ctrl(16'h0002); rd_stat(16'h4000);
    // Flush beats a simultaneous push.
    push(16'h0A01, 1'b0); push(16'h0A02, 1'b0); push(16'h0A03, 1'b0);
    vq.push_back(mk(1'b1, 16'h0A04, 1'b0, 1'b1, 16'h0002, 16'h0006, 16'h0000, 1'b0));
    rd_stat(16'h4000); rd_data(16'h0000, 1'b0);
    // Push and read on an empty FIFO: read gives 0, push is kept.
    vq.push_back(mk(1'b1, 16'h0C01, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0));
    rd_stat(16'h0001); rd_data(16'h0C01, 1'b0);
    // DATA writes ignored; unmapped reads return 0.
    vq.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h1234, 16'h0000, 1'b0));
    rd_stat(16'h4000);
    vq.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0003, 16'h0000, 16'h0000, 1'b0));
    vq.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0102, 16'h0000, 16'h0000, 1'b0));
    // Overflow set wins over a same-cycle clear.
    for (int i = 1; i <= 8; i++) push(16'h0D00 + 16'(i), 1'b0);
    vq.push_back(mk(1'b1, 16'h0D09, 1'b0, 1'b1, 16'h0002, 16'h0004, 16'h0000, 1'b0));
    rd_stat(16'hA008); wr_ctrl(16'h0002); rd_stat(16'hC000); wr_ctrl(16'h0004); rd_stat(16'h4000);

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].kv, vq[i].code, vq[i].rd, vq[i].wr, vq[i].addr, vq[i].wdata);
      chk16($sformatf("vec%0d_rdata", i), bus_rdata, vq[i].exp_rdata);
      chk1($sformatf("vec%0d_irq", i), key_irq, vq[i].exp_irq);
    end

    // Asynchronous reset with 5 codes queued and irq enabled.
    step(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0002, 16'h0001);
    for (int i = 1; i <= 5; i++) step(1'b1, 16'h0E00 + 16'(i), 1'b0, 1'b0, 16'h0000, 16'h0000);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0001, 16'h0000);
    chk16("pre_reset_status", bus_rdata, 16'h0005);
    chk1("pre_reset_irq", key_irq, 1'b1);
    drive(1'b1, 16'h0EFF, 1'b0, 1'b0, 16'h0000, 16'h0000);
    #2;
    global_rst_n = 1'b0;
    #1;
    chk16("async_reset_rdata", bus_rdata, 16'h0000);
    chk1("async_reset_irq", key_irq, 1'b0);
    @(posedge global_clk);
    @(negedge global_clk);
    global_rst_n = 1'b1;
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(posedge global_clk);
    #1;
    step(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0001, 16'h0000);
    chk16("post_reset_status", bus_rdata, 16'h4000);
    chk1("post_reset_irq", key_irq, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0002, 16'h0000);
    chk16("post_reset_ctrl", bus_rdata, 16'h0000);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000);
    chk16("post_reset_data", bus_rdata, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
